// File: rtl/game_tick_scheduler.sv
// Central game timing: shared prescaler, accelerating game-step tick and animation wave,
// gated by an IDLE/RUN/PAUSED/OVER state machine.
module game_tick_scheduler #(
  parameter int unsigned PRESCALE    = 2500000,
  parameter int unsigned SPEED_MIN   = 8,
  parameter int unsigned SPEED_MAX   = 2,
  parameter int unsigned LEVEL_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       collision,
  output logic       base_tick,
  output logic       game_tick,
  output logic       anim,
  output logic [1:0] state,
  output logic [3:0] level
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StOver   = 2'd3
  } state_e;

  localparam logic [29:0] PrescLast = 30'(PRESCALE - 1);
  localparam logic [7:0]  SpeedMin  = 8'(SPEED_MIN);
  localparam logic [7:0]  SpeedMax  = 8'(SPEED_MAX);
  localparam logic [7:0]  LevelLast = 8'(LEVEL_TICKS - 1);

  state_e      state_q;
  logic [29:0] presc_q;
  logic [7:0]  div_q;
  logic [7:0]  lvl_cnt_q;
  logic [7:0]  speed_q;

  logic presc_wrap, div_wrap, lvl_wrap;

  always_comb begin
    presc_wrap = (presc_q == PrescLast);
    div_wrap   = (div_q == speed_q - 8'd1);
    lvl_wrap   = (lvl_cnt_q == LevelLast);
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      div_q     <= '0;
      lvl_cnt_q <= '0;
      speed_q   <= SpeedMin;
      level     <= '0;
      base_tick <= 1'b0;
      game_tick <= 1'b0;
      anim      <= 1'b0;
    end else begin
      base_tick <= 1'b0;
      game_tick <= 1'b0;
      unique case (state_q)
        StIdle, StOver: begin
          // Fresh game: every counter and the speed schedule restart from scratch.
          if (start) begin
            state_q   <= StRun;
            presc_q   <= '0;
            div_q     <= '0;
            lvl_cnt_q <= '0;
            speed_q   <= SpeedMin;
            level     <= '0;
            anim      <= 1'b0;
          end
        end
        StRun: begin
          // A wrap coinciding with collision/pause is dropped and the count is not advanced.
          if (collision) begin
            state_q <= StOver;
          end else if (pause) begin
            state_q <= StPaused;
          end else begin
            presc_q <= presc_wrap ? '0 : presc_q + 30'd1;
            if (presc_wrap) begin
              base_tick <= 1'b1;
              anim      <= ~anim;
              if (div_wrap) begin
                div_q     <= '0;
                game_tick <= 1'b1;
                if (lvl_wrap) begin
                  lvl_cnt_q <= '0;
                  if (speed_q > SpeedMax) speed_q <= speed_q - 8'd1;
                  if (level != 4'hf) level <= level + 4'd1;
                end else begin
                  lvl_cnt_q <= lvl_cnt_q + 8'd1;
                end
              end else begin
                div_q <= div_q + 8'd1;
              end
            end
          end
        end
        StPaused: begin
          if (collision) begin
            state_q <= StOver;
          end else if (!pause) begin
            state_q <= StRun;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: expected tick edges are queued when stimulus is
// driven and popped as the DUT reaches each edge.
module tb_game_tick_scheduler;

  logic       clk, rst_n, start, pause, collision;
  logic       base_tick, game_tick, anim;
  logic [1:0] state;
  logic [3:0] level;

  game_tick_scheduler #(
    .PRESCALE   (4),
    .SPEED_MIN  (3),
    .SPEED_MAX  (1),
    .LEVEL_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .collision(collision),
    .base_tick(base_tick),
    .game_tick(game_tick),
    .anim     (anim),
    .state    (state),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int e = 0;
  int e0, e1;
  int gcount = 0;
  int exp_level = 0;
  logic exp_anim = 1'b0;
  int bq[$];
  int gq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic ebt, egt;
    ebt = (bq.size() > 0) && (bq[0] == e);
    if (ebt) begin
      void'(bq.pop_front());
      exp_anim = ~exp_anim;
    end
    egt = (gq.size() > 0) && (gq[0] == e);
    if (egt) begin
      void'(gq.pop_front());
      gcount++;
      if ((gcount % 2 == 0) && (exp_level < 15)) exp_level++;
    end
    chk("base_tick", base_tick, ebt);
    chk("game_tick", game_tick, egt);
    chk("anim", anim, exp_anim);
    chk("level", level, exp_level);
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    #1;
    check_cycle();
  endtask

  initial begin
    int t, p;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; collision = 1'b0;
    repeat (3) step();
    chk("reset_state", state, 0);
    rst_n = 1'b1;
    step();

    // Pause and collision are ignored in IDLE.
    pause = 1'b1; step(); pause = 1'b0;
    chk("idle_pause", state, 0);
    collision = 1'b1; step(); collision = 1'b0;
    chk("idle_collision", state, 0);
    step();

    // Game 1: long run to level saturation.
    start = 1'b1; step(); start = 1'b0;
    e0 = e;
    chk("run_entry", state, 1);
    for (int k = 1; k <= 40; k++) bq.push_back(e0 + 4 * k);
    t = e0;
    for (int i = 0; i < 100; i++) begin
      p = (i < 2) ? 12 : ((i < 4) ? 8 : 4);
      t += p;
      if (t > e0 + 160) break;
      gq.push_back(t);
    end
    repeat (160) step();
    chk("level_saturated", level, 15);
    chk("still_run", state, 1);

    // Collision and pause together on a prescaler wrap edge.
    repeat (3) step();
    collision = 1'b1; pause = 1'b1; step(); collision = 1'b0; pause = 1'b0;
    chk("over_state", state, 3);
    chk("wrap_suppressed", base_tick, 0);
    repeat (5) step();
    chk("over_level_hold", level, 15);
    chk("over_state_hold", state, 3);

    // Game 2: restart from OVER, then pause with the prescaler at 2.
    exp_level = 0; gcount = 0; exp_anim = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    e1 = e;
    chk("restart_state", state, 1);
    chk("restart_level", level, 0);
    chk("restart_anim", anim, 0);
    for (int k = 1; k <= 6; k++) bq.push_back(e1 + 4 * k);
    for (int k = 0; k <= 4; k++) bq.push_back(e1 + 39 + 4 * k);
    gq.push_back(e1 + 12); gq.push_back(e1 + 24);
    gq.push_back(e1 + 43); gq.push_back(e1 + 51); gq.push_back(e1 + 55);
    repeat (26) step();
    pause = 1'b1; step();
    chk("paused_state", state, 2);
    repeat (9) step();
    chk("paused_hold", state, 2);
    pause = 1'b0; step();
    chk("resume_state", state, 1);
    repeat (18) step();
    chk("scoreboard_drained", bq.size() + gq.size(), 0);

    // Asynchronous reset between edges while ticks are high.
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_base", base_tick, 0);
    chk("async_game", game_tick, 0);
    chk("async_anim", anim, 0);
    chk("async_level", level, 0);
    exp_level = 0; gcount = 0; exp_anim = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    pause = 1'b1; step(); pause = 1'b0;
    chk("idle_pause2", state, 0);
    collision = 1'b1; step(); collision = 1'b0;
    chk("idle_collision2", state, 0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Central timing controller for the game: owns a single shared prescaler and sequences every slow enable the game logic consumes. It produces a base tick, a game-step tick whose rate speeds up as play progresses, and an animation square wave, all gated by a run/pause/game-over state machine. It sits between the 100 MHz-domain `clk` and the obstacle/player/score blocks, replacing free-running per-block dividers with synchronous single-cycle enables.

## Interface

- `PRESCALE`, default 2500000: clk cycles per base tick; must be >= 2; counter is 30 bits.
- `SPEED_MIN`, default 8: base ticks per game tick at level 0 (slowest); 1..255.
- `SPEED_MAX`, default 2: base ticks per game tick at the fastest level; 1..`SPEED_MIN`.
- `LEVEL_TICKS`, default 16: game ticks per level step; 1..255.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse: begin or restart a game.
- `pause`  in  1  level: freeze timing while high.
- `collision`  in  1  single-cycle pulse: ends the game.
- `base_tick`  out  1  registered one-cycle enable every `PRESCALE` clk cycles while running.
- `game_tick`  out  1  registered one-cycle enable, always coincident with a `base_tick`.
- `anim`  out  1  registered square wave, toggles on every `base_tick`.
- `state`  out  2  0 IDLE, 1 RUN, 2 PAUSED, 3 OVER.
- `level`  out  4  current difficulty level, saturates at 15.

## Operation

- Reset (async, `rst_n` low): state IDLE, prescaler 0, divider 0, level counter 0, speed = `SPEED_MIN`, `level` 0, `base_tick` 0, `game_tick` 0, `anim` 0.
- IDLE: all counters held at 0; `start` -> RUN. `pause` and `collision` ignored.
- RUN: prescaler counts 0..`PRESCALE`-1 and wraps. On wrap: `base_tick` pulses, `anim` toggles, divider advances 0..speed-1. On divider wrap: `game_tick` pulses, level counter advances 0..`LEVEL_TICKS`-1. On level-counter wrap: if speed > `SPEED_MAX` then speed -= 1; `level` += 1, saturating at 15. A new speed applies from the next divider period.
- RUN exits: `collision` -> OVER, with priority over `pause`. `pause` high -> PAUSED. `start` is ignored.
- PAUSED: all counters and `anim` frozen; no ticks. `pause` low -> RUN, resuming from the frozen counts. `collision` -> OVER.
- OVER: no ticks; counters and `level` hold their final values for score display. `start` -> RUN with every counter cleared, speed = `SPEED_MIN`, `level` 0, and `anim` 0.
- Only IDLE -> RUN and OVER -> RUN clear counters; the PAUSED <-> RUN transitions never clear them.

## Timing

- Entering RUN at edge E0 leaves the prescaler at 0 after E0. The first `base_tick` is high in the cycle after edge E0+`PRESCALE`; the pulses then repeat every `PRESCALE` cycles.
- `game_tick` period in RUN = speed × `PRESCALE` cycles. The first `game_tick` follows E0 by `SPEED_MIN` × `PRESCALE` cycles.
- Ticks are decided from the pre-edge state. If `collision` or `pause` is asserted in the same cycle the prescaler would wrap, that tick is suppressed; the paused case does not advance the count.
- `state` updates one edge after the qualifying input. Inputs are sampled only on `clk` edges; `start` and `collision` are taken as already synchronous.
- Reset asserted mid-game: all outputs go to their reset values immediately, without waiting for a clock edge.
- Counter widths: prescaler 30b, divider 8b, level counter 8b, speed 8b. No overflow is possible within the parameter ranges.

## Test plan

Bench parameters: `PRESCALE`=4, `SPEED_MIN`=3, `SPEED_MAX`=1, `LEVEL_TICKS`=2.

- Reset, then `start` pulse -> `state`=1. `base_tick` first high 4 cycles after entry, then every 4 cycles. `anim` toggles with each pulse. `game_tick` on every 3rd `base_tick` (period 12).
- Run through 2 game ticks -> `level`=1 and the `game_tick` period becomes 8. After 2 more -> `level`=2 and the period is 4, staying at 4 thereafter while `level` keeps rising and saturates at 15.
- Assert `pause` for 10 cycles mid-period with the prescaler at 2 -> `state`=2, no ticks, `anim` constant. On release, the next `base_tick` arrives 2 cycles after returning to RUN.
- `collision` and `pause` in the same cycle as a prescaler wrap -> `state`=3 and no `base_tick` that cycle. `level` holds its value. A later `start` -> `state`=1 with `level`=0, `anim`=0, and a `game_tick` period of 12.
- `rst_n` low mid-RUN between clock edges -> `state`=0 and all outputs 0 immediately. `collision` or `pause` in IDLE -> `state` stays 0.
